if0_pc_gen: RTL

- Fetch-PC generator ahead of IF0; owns the architectural fetch PC register.
- Each cycle it selects the next fetch address from, highest priority first:
  - CSR/exception redirect
  - EX branch-resolution redirect
  - BTB prediction
  - sequential fetch-packet increment
- Drives the BTB lookup PC and the IF0 request. Fetch packets are 8 bytes; BTB indexing starts at bit 3.

---
 rtl/if0_pc_gen_pkg.sv | 32 +++
 rtl/if0_next_pc_sel.sv | 86 ++++++++
 rtl/if0_pc_gen_chk.sv | 15 +
 rtl/if0_pc_gen.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/if0_pc_gen_pkg.sv
// Shared types, constants and helpers for the IF0 fetch-PC generator.
package if0_pc_gen_pkg;

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_IDLE = 2'd2
    } pc_state_e;

    localparam int unsigned FETCH_BYTES      = 8;
    localparam int unsigned FETCH_ALIGN_LSB  = $clog2(FETCH_BYTES);
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h1c00_0000;

    // Start of the next fetch packet; unaligned PCs are realigned, top of memory wraps to 0.
    function automatic logic [31:0] seq_next_pc(input logic [31:0] pc);
        logic [31-FETCH_ALIGN_LSB:0] blk;
        blk = pc[31:FETCH_ALIGN_LSB] + (32-FETCH_ALIGN_LSB)'(1);
        return {blk, {FETCH_ALIGN_LSB{1'b0}}};
    endfunction

    // Saturating 32-bit increment for event counters.
    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        logic [31:0] r;
        if (v == 32'hFFFF_FFFF) begin
            r = v;
        end else begin
            r = v + 32'd1;
        end
        return r;
    endfunction

endpackage

// File: rtl/if0_next_pc_sel.sv
// Combinational next-fetch-PC priority mux: CSR > EX > idle > BTB > sequential.
module if0_next_pc_sel
    import if0_pc_gen_pkg::*;
(
    input  pc_state_e   state,
    input  logic [31:0] pc,
    input  logic        boot_done,
    input  logic        if0_allowin,
    input  logic [31:0] pred_pc,
    input  logic        pred_taken,
    input  logic        ex_redirect,
    input  logic [31:0] ex_target,
    input  logic        csr_redirect,
    input  logic [31:0] csr_target,
    input  logic        idle_req,
    input  logic        wake,
    output logic [31:0] next_pc,
    output logic        flush_if,
    output pc_state_e   state_next,
    output logic        pred_used
);

    // Select next PC, flush and state hint according to current state and redirect priority.
    always_comb begin
        next_pc    = pc;
        flush_if   = 1'b0;
        state_next = state;
        pred_used  = 1'b0;
        case (state)
            ST_BOOT: begin
                // Fetch is not live yet: a CSR target may be preloaded, EX is ignored.
                if (csr_redirect) begin
                    next_pc = csr_target;
                end else begin
                    next_pc = pc;
                end
                if (boot_done) begin
                    state_next = ST_RUN;
                end else begin
                    state_next = ST_BOOT;
                end
            end
            ST_RUN: begin
                if (csr_redirect) begin
                    next_pc  = csr_target;
                    flush_if = 1'b1;
                end else if (ex_redirect) begin
                    next_pc  = ex_target;
                    flush_if = 1'b1;
                end else if (idle_req) begin
                    next_pc    = seq_next_pc(pc);
                    flush_if   = 1'b1;
                    state_next = ST_IDLE;
                end else if (if0_allowin) begin
                    if (pred_taken) begin
                        next_pc   = pred_pc;
                        pred_used = 1'b1;
                    end else begin
                        next_pc = seq_next_pc(pc);
                    end
                end else begin
                    next_pc = pc;
                end
            end
            ST_IDLE: begin
                if (csr_redirect) begin
                    next_pc    = csr_target;
                    flush_if   = 1'b1;
                    state_next = ST_RUN;
                end else if (wake) begin
                    next_pc    = pc;
                    state_next = ST_RUN;
                end else begin
                    next_pc    = pc;
                    state_next = ST_IDLE;
                end
            end
            default: begin
                // Unreachable encoding: fall back to a clean boot sequence.
                next_pc    = pc;
                state_next = ST_BOOT;
            end
        endcase
    end

endmodule

// File: rtl/if0_pc_gen_chk.sv
// Protocol checker for the fetch-PC generator: EX must not redirect while fetch is idle.
module if0_pc_gen_chk
    import if0_pc_gen_pkg::*;
(
    input logic      clk,
    input logic      rst,
    input pc_state_e state,
    input logic      ex_redirect
);

    // An EX mispredict cannot exist while the pipeline is drained in IDLE.
    a_no_ex_in_idle: assert property (@(posedge clk) disable iff (rst)
        !((state == ST_IDLE) && ex_redirect));

endmodule

// File: rtl/if0_pc_gen.sv
// Fetch-PC generator ahead of IF0: owns the fetch PC, boot/run/idle FSM.
// Optional macro PC_GEN_PERF_EN adds saturating fetch/redirect/prediction counters.
module if0_pc_gen
    import if0_pc_gen_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = RESET_PC_DEFAULT,
    parameter int unsigned BOOT_CYCLES = 2
)(
    input  logic        clk,
    input  logic        rst,
    input  logic        if0_allowin,
    output logic [31:0] fetch_pc,
    output logic        fetch_valid,
    output logic        fetch_adef,
    output logic        flush_if,
    input  logic [31:0] pred_pc,
    input  logic        pred_taken,
    input  logic        ex_redirect,
    input  logic [31:0] ex_target,
    input  logic        csr_redirect,
    input  logic [31:0] csr_target,
    input  logic        idle_req,
    input  logic        wake
`ifdef PC_GEN_PERF_EN
    ,
    output logic [31:0] perf_fetch_cnt,
    output logic [31:0] perf_redirect_cnt,
    output logic [31:0] perf_pred_cnt
`endif
);

    localparam logic [3:0] BOOT_LAST = 4'(BOOT_CYCLES - 1);

    logic [31:0] pc_q, pc_d;
    pc_state_e   state_q, state_d;
    logic [3:0]  boot_cnt_q, boot_cnt_d;

    logic [31:0] next_pc_s;
    logic        flush_if_s;
    pc_state_e   state_next_s;
    logic        pred_used_s;
    logic        boot_done_s;

    assign boot_done_s = (boot_cnt_q == BOOT_LAST);

    if0_next_pc_sel u_sel (
        .state        (state_q),
        .pc           (pc_q),
        .boot_done    (boot_done_s),
        .if0_allowin  (if0_allowin),
        .pred_pc      (pred_pc),
        .pred_taken   (pred_taken),
        .ex_redirect  (ex_redirect),
        .ex_target    (ex_target),
        .csr_redirect (csr_redirect),
        .csr_target   (csr_target),
        .idle_req     (idle_req),
        .wake         (wake),
        .next_pc      (next_pc_s),
        .flush_if     (flush_if_s),
        .state_next   (state_next_s),
        .pred_used    (pred_used_s)
    );

    if0_pc_gen_chk u_chk (
        .clk         (clk),
        .rst         (rst),
        .state       (state_q),
        .ex_redirect (ex_redirect)
    );

    // Next values for PC, FSM state and boot counter.
    always_comb begin
        pc_d    = next_pc_s;
        state_d = state_next_s;
        if ((state_q == ST_BOOT) && !boot_done_s) begin
            boot_cnt_d = boot_cnt_q + 4'd1;
        end else begin
            boot_cnt_d = boot_cnt_q;
        end
    end

    // PC register, FSM state and boot counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q       <= RESET_PC;
            state_q    <= ST_BOOT;
            boot_cnt_q <= 4'd0;
        end else begin
            pc_q       <= pc_d;
            state_q    <= state_d;
            boot_cnt_q <= boot_cnt_d;
        end
    end

    assign fetch_pc    = pc_q;
    assign fetch_valid = (state_q == ST_RUN);
    assign fetch_adef  = (state_q == ST_RUN) && (pc_q[1:0] != 2'b00);
    assign flush_if    = flush_if_s;

`ifdef PC_GEN_PERF_EN
    logic [31:0] perf_fetch_q, perf_fetch_d;
    logic [31:0] perf_redirect_q, perf_redirect_d;
    logic [31:0] perf_pred_q, perf_pred_d;

    // Saturating event counts for accepted fetches, redirects and used predictions.
    always_comb begin
        if (fetch_valid && if0_allowin) begin
            perf_fetch_d = sat_inc32(perf_fetch_q);
        end else begin
            perf_fetch_d = perf_fetch_q;
        end
        if (flush_if_s) begin
            perf_redirect_d = sat_inc32(perf_redirect_q);
        end else begin
            perf_redirect_d = perf_redirect_q;
        end
        if (pred_used_s) begin
            perf_pred_d = sat_inc32(perf_pred_q);
        end else begin
            perf_pred_d = perf_pred_q;
        end
    end

    // Performance counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_fetch_q    <= 32'd0;
            perf_redirect_q <= 32'd0;
            perf_pred_q     <= 32'd0;
        end else begin
            perf_fetch_q    <= perf_fetch_d;
            perf_redirect_q <= perf_redirect_d;
            perf_pred_q     <= perf_pred_d;
        end
    end

    assign perf_fetch_cnt    = perf_fetch_q;
    assign perf_redirect_cnt = perf_redirect_q;
    assign perf_pred_cnt     = perf_pred_q;
`else
    logic unused_pred_used_s;
    assign unused_pred_used_s = pred_used_s;
`endif

endmodule
